// File: rtl/cnn_mac_acc_14s_if.sv
// Product-in / result-out bundle for the conv MAC accumulator stage.
// The master side is the upstream multiplier plus downstream consumer; the slave side is the accumulator.
interface cnn_mac_acc_14s_if #(
  parameter int PROD_W = 21,
  parameter int OUT_W  = 14
);
  logic signed [PROD_W-1:0] in_prod;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  bias_in;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  modport master (
    output in_prod, in_valid, bias_in, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_prod, in_valid, bias_in, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/cnn_mac_acc_14s.sv
// Window accumulator: bias + TAPS products, round-half-up, saturate to OUT_W.
// Define CNN_MAC_RELU_EN to clamp negative results to zero after saturation.
module cnn_mac_acc_14s #(
  parameter int PROD_W = 21,
  parameter int ACC_W  = 28,
  parameter int OUT_W  = 14,
  parameter int TAPS   = 25,
  parameter int SHIFT  = 6
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  cnn_mac_acc_14s_if.slave  bus
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     run_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0]  bias;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, acc_sum;
  logic signed [ACC_W:0]    rnd_sum, shifted;
  logic signed [OUT_W-1:0]  sat_res, res;
  logic                     in_ready, accept;

  assign prod     = bus.in_prod;
  assign bias     = bus.bias_in;
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'(bias) <<< SHIFT;
  assign acc_sum  = (count_q == '0) ? (bias_ext + prod_ext) : (acc_q + prod_ext);

  // Widen by one bit so adding the half-LSB can never wrap.
  assign rnd_sum  = (ACC_W+1)'(acc_sum) + HALF;
  assign shifted  = rnd_sum >>> SHIFT;

  always_comb begin
    sat_res = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_res = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_res = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

`ifdef CNN_MAC_RELU_EN
  assign res = sat_res[OUT_W-1] ? '0 : sat_res;
`else
  assign res = sat_res;
`endif

  // run_q keeps in_ready low throughout reset without a path from ap_rst_n.
  assign in_ready = run_q && (state_q == ST_ACC);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          acc_d = acc_sum;
          if (count_q == LAST_CNT) begin
            count_d    = '0;
            out_data_d = res;
            state_d    = ST_OUT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= ST_ACC;
      count_q    <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      run_q      <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (count_q != '0) || (state_q == ST_OUT);

endmodule
